// File: rtl/flag_hist_pkg.sv
// rtl/flag_hist_pkg.sv - flag indices, default sizes and counter-width helper for the flag history
package flag_hist_pkg;

  localparam int FLAG_C        = 0;
  localparam int FLAG_Z        = 1;
  localparam int DEF_NUM_FLAGS = 2;
  localparam int DEF_DEPTH     = 3;

  // Width needed to count 0..depth inclusive.
  function automatic int clog2_p1(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flag_hist_stage.sv
// rtl/flag_hist_stage.sv - one history entry (flags + valid) with clear > load > hold
module flag_hist_stage
  import flag_hist_pkg::*;
#(
  parameter int NUM_FLAGS = DEF_NUM_FLAGS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 load,
  input  logic [NUM_FLAGS-1:0] d_flags,
  input  logic                 d_valid,
  output logic [NUM_FLAGS-1:0] q_flags,
  output logic                 q_valid
);

  logic [NUM_FLAGS-1:0] r_flags;
  logic                 r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= '0;
      r_valid <= 1'b0;
    end else if (clear) begin
      r_flags <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_flags <= d_flags;
      r_valid <= d_valid;
    end
  end

  assign q_flags = r_flags;
  assign q_valid = r_valid;

endmodule

// File: rtl/flag_history_pipe.sv
// rtl/flag_history_pipe.sv - shifting condition-flag history with masked merge, stall, flush and read port
// Optional same-cycle read forwarding: FLAG_BYPASS_EN.
module flag_history_pipe
  import flag_hist_pkg::*;
#(
  parameter int NUM_FLAGS = DEF_NUM_FLAGS,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int SEL_W     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [NUM_FLAGS-1:0]         flag_we,
  input  logic [NUM_FLAGS-1:0]         flag_in,
  input  logic [SEL_W-1:0]             rd_sel,
  output logic [NUM_FLAGS-1:0]         rd_flags,
  output logic                         rd_valid,
  output logic [NUM_FLAGS*DEPTH-1:0]   hist_flags,
  output logic [clog2_p1(DEPTH)-1:0]   valid_cnt
);

  localparam int CNT_W = clog2_p1(DEPTH);

  logic                 w_push;
  logic [NUM_FLAGS-1:0] w_new0;
  logic [NUM_FLAGS-1:0] w_q_flags [DEPTH];
  logic                 w_q_valid [DEPTH];
  logic [NUM_FLAGS-1:0] w_d_flags [DEPTH];
  logic                 w_d_valid [DEPTH];
  logic [CNT_W-1:0]     r_cnt;

  assign w_push = (|flag_we) & ~stall & ~flush;
  // Masked flags carry forward the newest value, even from an invalid entry0.
  assign w_new0 = (flag_we & flag_in) | (~flag_we & w_q_flags[0]);

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_d_flags[k] = w_new0;
      assign w_d_valid[k] = 1'b1;
    end else begin : g_tail
      assign w_d_flags[k] = w_q_flags[k-1];
      assign w_d_valid[k] = w_q_valid[k-1];
    end

    flag_hist_stage #(.NUM_FLAGS(NUM_FLAGS)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .clear   (flush),
      .load    (w_push),
      .d_flags (w_d_flags[k]),
      .d_valid (w_d_valid[k]),
      .q_flags (w_q_flags[k]),
      .q_valid (w_q_valid[k])
    );

    assign hist_flags[k*NUM_FLAGS +: NUM_FLAGS] = w_q_flags[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_push && (r_cnt != CNT_W'(DEPTH))) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign valid_cnt = r_cnt;

  // Stage d-inputs are exactly the post-shift view, so forwarding reuses them.
  always_comb begin
    rd_flags = '0;
    rd_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (int'(rd_sel) == k) begin
`ifdef FLAG_BYPASS_EN
        if (w_push) begin
          rd_flags = w_d_flags[k];
          rd_valid = w_d_valid[k];
        end else begin
          rd_flags = w_q_flags[k];
          rd_valid = w_q_valid[k];
        end
`else
        rd_flags = w_q_flags[k];
        rd_valid = w_q_valid[k];
`endif
      end
    end
  end

endmodule

// File: tb/tb_flag_history_pipe.sv
// tb/tb_flag_history_pipe.sv - directed self-checking bench for flag_history_pipe (DEPTH 3, 2 flags)
module tb_flag_history_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       flush;
  logic [1:0] flag_we;
  logic [1:0] flag_in;
  logic [1:0] rd_sel;
  logic [1:0] rd_flags;
  logic       rd_valid;
  logic [5:0] hist_flags;
  logic [1:0] valid_cnt;

  int checks = 0;
  int errors = 0;

  flag_history_pipe #(.NUM_FLAGS(2), .DEPTH(3), .SEL_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .flag_we    (flag_we),
    .flag_in    (flag_in),
    .rd_sel     (rd_sel),
    .rd_flags   (rd_flags),
    .rd_valid   (rd_valid),
    .hist_flags (hist_flags),
    .valid_cnt  (valid_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] we, input logic [1:0] din);
    flag_we = we;
    flag_in = din;
    tick();
    flag_we = 2'b00;
    flag_in = 2'b00;
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    flag_we = 2'b00; flag_in = 2'b00; rd_sel = 2'd0;
    #12;
    checks++; if (hist_flags !== 6'b0) begin errors++; $display("FAIL reset_hist got %b want %b", hist_flags, 6'b0); end
    checks++; if (valid_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", valid_cnt); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_push_shift();
    push(2'b11, 2'b01);
    checks++; if (valid_cnt !== 2'd1) begin errors++; $display("FAIL push1_cnt got %0d want 1", valid_cnt); end
    push(2'b11, 2'b10);
    push(2'b11, 2'b11);
    checks++; if (hist_flags !== 6'b01_10_11) begin errors++; $display("FAIL push3_hist got %b want %b", hist_flags, 6'b01_10_11); end
    checks++; if (valid_cnt !== 2'd3) begin errors++; $display("FAIL push3_cnt got %0d want 3", valid_cnt); end
    rd_sel = 2'd1; #1;
    checks++; if (rd_flags !== 2'b10 || rd_valid !== 1'b1) begin errors++; $display("FAIL push3_rd1 got %b/%b want 10/1", rd_flags, rd_valid); end
    rd_sel = 2'd0;
    push(2'b11, 2'b00);
    checks++; if (hist_flags !== 6'b10_11_00) begin errors++; $display("FAIL push4_hist got %b want %b", hist_flags, 6'b10_11_00); end
    checks++; if (valid_cnt !== 2'd3) begin errors++; $display("FAIL push4_cnt_sat got %0d want 3", valid_cnt); end
  endtask

  task automatic test_masked();
    do_flush();
    push(2'b01, 2'b11);
    checks++; if (hist_flags !== 6'b00_00_01) begin errors++; $display("FAIL mask_after_flush got %b want %b", hist_flags, 6'b00_00_01); end
    push(2'b10, 2'b10);
    checks++; if (hist_flags !== 6'b00_01_11) begin errors++; $display("FAIL mask_carry_fwd got %b want %b", hist_flags, 6'b00_01_11); end
    checks++; if (valid_cnt !== 2'd2) begin errors++; $display("FAIL mask_cnt got %0d want 2", valid_cnt); end
  endtask

  task automatic test_stall_flush();
    stall = 1'b1; flag_we = 2'b11; flag_in = 2'b10;
    tick();
    checks++; if (hist_flags !== 6'b00_01_11) begin errors++; $display("FAIL stall_hist got %b want %b", hist_flags, 6'b00_01_11); end
    checks++; if (valid_cnt !== 2'd2) begin errors++; $display("FAIL stall_cnt got %0d want 2", valid_cnt); end
    flush = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0; flag_we = 2'b00; flag_in = 2'b00; rd_sel = 2'd0;
    #1;
    checks++; if (hist_flags !== 6'b0) begin errors++; $display("FAIL flush_stall_hist got %b want 0", hist_flags); end
    checks++; if (valid_cnt !== 2'd0) begin errors++; $display("FAIL flush_stall_cnt got %0d want 0", valid_cnt); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL flush_stall_rd_valid got %b want 0", rd_valid); end
  endtask

  task automatic test_read_oob_hold();
    push(2'b11, 2'b11);
    push(2'b11, 2'b01);
    rd_sel = 2'd3; #1;
    checks++; if (rd_flags !== 2'b00 || rd_valid !== 1'b0) begin errors++; $display("FAIL rd_oob got %b/%b want 00/0", rd_flags, rd_valid); end
    rd_sel = 2'd2; #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_invalid_entry got %b want 0", rd_valid); end
    flag_we = 2'b00; flag_in = 2'b11;
    for (int i = 0; i < 5; i++) tick();
    flag_in = 2'b00;
    checks++; if (hist_flags !== 6'b00_11_01) begin errors++; $display("FAIL hold_hist got %b want %b", hist_flags, 6'b00_11_01); end
    checks++; if (valid_cnt !== 2'd2) begin errors++; $display("FAIL hold_cnt got %0d want 2", valid_cnt); end
  endtask

  task automatic test_bypass();
    flag_we = 2'b11; flag_in = 2'b10; rd_sel = 2'd0; #1;
`ifdef FLAG_BYPASS_EN
    checks++; if (rd_flags !== 2'b10 || rd_valid !== 1'b1) begin errors++; $display("FAIL bypass_rd0 got %b/%b want 10/1", rd_flags, rd_valid); end
    rd_sel = 2'd1; #1;
    checks++; if (rd_flags !== 2'b01 || rd_valid !== 1'b1) begin errors++; $display("FAIL bypass_rd1 got %b/%b want 01/1", rd_flags, rd_valid); end
    checks++; if (hist_flags !== 6'b00_11_01) begin errors++; $display("FAIL bypass_hist_reg got %b want %b", hist_flags, 6'b00_11_01); end
`else
    checks++; if (rd_flags !== 2'b01 || rd_valid !== 1'b1) begin errors++; $display("FAIL nobypass_rd0 got %b/%b want 01/1", rd_flags, rd_valid); end
    rd_sel = 2'd1; #1;
    checks++; if (rd_flags !== 2'b11 || rd_valid !== 1'b1) begin errors++; $display("FAIL nobypass_rd1 got %b/%b want 11/1", rd_flags, rd_valid); end
`endif
    tick();
    flag_we = 2'b00; flag_in = 2'b00; rd_sel = 2'd0; #1;
    checks++; if (rd_flags !== 2'b10 || valid_cnt !== 2'd3) begin errors++; $display("FAIL post_bypass_push got %b/%0d want 10/3", rd_flags, valid_cnt); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (hist_flags !== 6'b0) begin errors++; $display("FAIL midreset_hist got %b want 0", hist_flags); end
    checks++; if (valid_cnt !== 2'd0) begin errors++; $display("FAIL midreset_cnt got %0d want 0", valid_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_push_shift();
    test_masked();
    test_stall_flush();
    test_read_oob_hold();
    test_bypass();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
